// File: rtl/jacobi_pivot_search.sv
// Pivot search for the Jacobi eigen-solver: scans the strict upper triangle for the largest |a_ij|,
// then fetches a_pp/a_qq. Optional macro JACOBI_PIVOT_THRESH_EN enables the convergence threshold.
module jacobi_pivot_search #(
  parameter int N  = 32,
  parameter int W  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          mat_rd_en,
  output logic [AW-1:0] mat_rd_row,
  output logic [AW-1:0] mat_rd_col,
  input  logic [W-1:0]  mat_rd_data,
  input  logic [W-1:0]  thresh,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic [W-1:0]  a_pp,
  output logic [W-1:0]  a_qq,
  output logic [W-1:0]  a_pq,
  output logic          ready_flag,
  output logic          converged
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_FLUSH = 3'd2,
    S_RD_PP = 3'd3,
    S_RD_QQ = 3'd4,
    S_CAP   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Saturating magnitude: the most negative code maps to the largest positive code.
  function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
    logic [W-1:0] r;
    if (x == {1'b1, {(W-1){1'b0}}}) begin
      r = {1'b0, {(W-1){1'b1}}};
    end else if (x[W-1]) begin
      r = ~x + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d;
  logic          tag_vld_q, tag_vld_d;
  logic [AW-1:0] tag_i_q, tag_i_d, tag_j_q, tag_j_d;
  logic          first_q, first_d;
  logic [W-1:0]  max_abs_q, max_abs_d, max_val_q, max_val_d;
  logic [AW-1:0] max_i_q, max_i_d, max_j_q, max_j_d;
  logic [W-1:0]  app_q, app_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic [W-1:0]  a_pp_q, a_pp_d, a_qq_q, a_qq_d, a_pq_q, a_pq_d;
  logic          ready_q, ready_d, conv_q, conv_d;
  logic          rd_en_s;
  logic [AW-1:0] rd_row_s, rd_col_s;
  logic          last_pair_s;
  logic [W-1:0]  rd_abs_s;
  logic          below_thresh_s;

  assign last_pair_s = (i_q == AW'(N-2)) && (j_q == AW'(N-1));
  assign rd_abs_s    = sat_abs(mat_rd_data);

`ifdef JACOBI_PIVOT_THRESH_EN
  assign below_thresh_s = (max_abs_q < thresh);
`else
  logic unused_thresh_s;
  assign unused_thresh_s = ^thresh;
  assign below_thresh_s  = 1'b0;
`endif

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      tag_vld_q <= 1'b0;
      tag_i_q   <= '0;
      tag_j_q   <= '0;
      first_q   <= 1'b0;
      max_abs_q <= '0;
      max_val_q <= '0;
      max_i_q   <= '0;
      max_j_q   <= '0;
      app_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      a_pp_q    <= '0;
      a_qq_q    <= '0;
      a_pq_q    <= '0;
      ready_q   <= 1'b0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      tag_vld_q <= tag_vld_d;
      tag_i_q   <= tag_i_d;
      tag_j_q   <= tag_j_d;
      first_q   <= first_d;
      max_abs_q <= max_abs_d;
      max_val_q <= max_val_d;
      max_i_q   <= max_i_d;
      max_j_q   <= max_j_d;
      app_q     <= app_d;
      row_q     <= row_d;
      col_q     <= col_d;
      a_pp_q    <= a_pp_d;
      a_qq_q    <= a_qq_d;
      a_pq_q    <= a_pq_d;
      ready_q   <= ready_d;
      conv_q    <= conv_d;
    end
  end

  // Next-state, scan sequencing, running-max compare and result capture.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    tag_vld_d = 1'b0;
    tag_i_d   = tag_i_q;
    tag_j_d   = tag_j_q;
    first_d   = first_q;
    max_abs_d = max_abs_q;
    max_val_d = max_val_q;
    max_i_d   = max_i_q;
    max_j_d   = max_j_q;
    app_d     = app_q;
    row_d     = row_q;
    col_d     = col_q;
    a_pp_d    = a_pp_q;
    a_qq_d    = a_qq_q;
    a_pq_d    = a_pq_q;
    ready_d   = 1'b0;
    conv_d    = 1'b0;
    rd_en_s   = 1'b0;
    rd_row_s  = '0;
    rd_col_s  = '0;

    // Strict '>' keeps the earliest pair in scan order on ties.
    if (tag_vld_q) begin
      if (first_q || (rd_abs_s > max_abs_q)) begin
        max_abs_d = rd_abs_s;
        max_val_d = mat_rd_data;
        max_i_d   = tag_i_q;
        max_j_d   = tag_j_q;
      end else begin
        max_abs_d = max_abs_q;
      end
      first_d = 1'b0;
    end else begin
      first_d = first_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          i_d     = '0;
          j_d     = AW'(1);
          first_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        rd_en_s   = 1'b1;
        rd_row_s  = i_q;
        rd_col_s  = j_q;
        tag_vld_d = 1'b1;
        tag_i_d   = i_q;
        tag_j_d   = j_q;
        if (last_pair_s) begin
          state_d = S_FLUSH;
        end else if (j_q == AW'(N-1)) begin
          i_d = i_q + AW'(1);
          j_d = i_q + AW'(2);
        end else begin
          j_d = j_q + AW'(1);
        end
      end
      S_FLUSH: begin
        state_d = S_RD_PP;
      end
      S_RD_PP: begin
        rd_en_s  = 1'b1;
        rd_row_s = max_i_q;
        rd_col_s = max_i_q;
        state_d  = S_RD_QQ;
      end
      S_RD_QQ: begin
        rd_en_s  = 1'b1;
        rd_row_s = max_j_q;
        rd_col_s = max_j_q;
        app_d    = mat_rd_data;
        state_d  = S_CAP;
      end
      S_CAP: begin
        row_d   = max_i_q;
        col_d   = max_j_q;
        a_pp_d  = app_q;
        a_qq_d  = mat_rd_data;
        a_pq_d  = max_val_q;
        if (below_thresh_s) begin
          conv_d = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign mat_rd_en  = rd_en_s;
  assign mat_rd_row = rd_row_s;
  assign mat_rd_col = rd_col_s;
  assign row        = row_q;
  assign col        = col_q;
  assign a_pp       = a_pp_q;
  assign a_qq       = a_qq_q;
  assign a_pq       = a_pq_q;
  assign ready_flag = ready_q;
  assign converged  = conv_q;

endmodule

// File: tb/tb_jacobi_pivot_search.sv
// Self-checking bench for jacobi_pivot_search: directed and randomized matrices checked against
// a loop-based reference search over the upper triangle.
module tb_jacobi_pivot_search;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = $clog2(N);
  localparam int P  = N * (N - 1) / 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          mat_rd_en;
  logic [AW-1:0] mat_rd_row, mat_rd_col;
  logic [W-1:0]  mat_rd_data;
  logic [W-1:0]  thresh;
  logic [AW-1:0] row, col;
  logic [W-1:0]  a_pp, a_qq, a_pq;
  logic          ready_flag, converged;

  logic [W-1:0] mat [N][N];
  int checks = 0;
  int errors = 0;

  jacobi_pivot_search #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .mat_rd_en(mat_rd_en), .mat_rd_row(mat_rd_row), .mat_rd_col(mat_rd_col),
    .mat_rd_data(mat_rd_data), .thresh(thresh),
    .row(row), .col(col), .a_pp(a_pp), .a_qq(a_qq), .a_pq(a_pq),
    .ready_flag(ready_flag), .converged(converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous matrix memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mat_rd_en) mat_rd_data <= mat[mat_rd_row][mat_rd_col];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    if ($signed(x) < 0) return 32'(-$signed(x));
    return x;
  endfunction

  // Reference: largest saturated magnitude, first occurrence in row-major order.
  task automatic model(output int ep, output int eq);
    logic [31:0] best;
    best = 32'h0;
    ep = -1;
    eq = -1;
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++)
        if (ep < 0 || mag(mat[i][j]) > best) begin
          best = mag(mat[i][j]);
          ep = i;
          eq = j;
        end
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = (i == j) ? 32'h4000_0000 : 32'h0;
  endtask

  task automatic set_pair(input int i, input int j, input logic [31:0] v);
    mat[i][j] = v;
    mat[j][i] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start in the current cycle (cycle 0) and run until a pulse; optionally re-pulse start at cycle inj.
  task automatic do_case(input string name, input int inj);
    int ep, eq, pc, idle_cnt, viol, rd_cnt;
    logic rf, cv, exp_cv;
    logic [AW-1:0] held_row;
    model(ep, eq);
`ifdef JACOBI_PIVOT_THRESH_EN
    exp_cv = (mag(mat[ep][eq]) < thresh);
`else
    exp_cv = 1'b0;
`endif
    pc = -1; idle_cnt = 0; viol = 0; rd_cnt = 0; rf = 1'b0; cv = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      start = (c == inj);
      if (!busy) idle_cnt++;
      if (!mat_rd_en && (mat_rd_row != '0 || mat_rd_col != '0)) viol++;
      if (mat_rd_en) rd_cnt++;
      if (ready_flag || converged) begin
        pc = c; rf = ready_flag; cv = converged;
        break;
      end
      step();
    end
    start = 1'b0;
    check({name, ".pulse_cycle"}, 64'(pc), 64'(P + 5));
    check({name, ".ready_flag"}, 64'(rf), 64'(!exp_cv));
    check({name, ".converged"}, 64'(cv), 64'(exp_cv));
    check({name, ".row"}, 64'(row), 64'(ep));
    check({name, ".col"}, 64'(col), 64'(eq));
    check({name, ".a_pq"}, 64'(a_pq), 64'(mat[ep][eq]));
    check({name, ".a_pp"}, 64'(a_pp), 64'(mat[ep][ep]));
    check({name, ".a_qq"}, 64'(a_qq), 64'(mat[eq][eq]));
    check({name, ".busy_gaps"}, 64'(idle_cnt), 64'(0));
    check({name, ".rd_idx_zero"}, 64'(viol), 64'(0));
    check({name, ".rd_count"}, 64'(rd_cnt), 64'(P + 2));
    held_row = row;
    step();
    check({name, ".pulse_width"}, 64'(ready_flag | converged), 64'(0));
    check({name, ".busy_after"}, 64'(busy), 64'(0));
    check({name, ".row_held"}, 64'(row), 64'(held_row));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thresh = 32'h0; mat_rd_data = 32'h0;
    set_identity();
    step();
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.rd_en", 64'(mat_rd_en), 64'(0));
    check("rst.flags", 64'({ready_flag, converged}), 64'(0));
    check("rst.rowcol", 64'({row, col, mat_rd_row, mat_rd_col}), 64'(0));
    check("rst.vals", 64'(a_pp | a_qq | a_pq), 64'(0));
    step();
    reset = 1'b0;
    step();

    set_identity();
    set_pair(3, 7, 32'h2000_0000);
    do_case("pivot_3_7", 0);

    set_identity();
    set_pair(1, 2, 32'h1000_0000);
    set_pair(5, 9, 32'hF000_0000);
    do_case("tie_mag", 0);

    set_identity();
    set_pair(0, 4, 32'h2800_0000);
    set_pair(6, 8, 32'hD000_0000);
    do_case("neg_sign", 0);

    set_identity();
    set_pair(2, 30, 32'h8000_0000);
    set_pair(0, 1, 32'h7FFF_FFFF);
    do_case("sat_tie", 0);

    set_identity();
    set_pair(30, 31, 32'h0000_0001);
    do_case("last_pair", 0);

    // Randomized: full-range values with frequent saturating codes, then small values with many ties.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        mat[i][i] = $urandom;
        for (int j = i + 1; j < N; j++) begin
          if (k == 0) set_pair(i, j, ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom);
          else set_pair(i, j, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255))
                                                          : 32'(-$urandom_range(0, 255)));
        end
      end
      do_case((k == 0) ? "rand_full" : "rand_small", 0);
    end

    // Reset in mid-scan, then a fresh scan with a start pulse that must be ignored.
    set_identity();
    set_pair(4, 5, 32'h1234_0000);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (ready_flag || converged) check("rst_mid.early_pulse", 64'(c), 64'(0));
      step();
    end
    reset = 1'b1;
    #2;
    check("rst_mid.busy", 64'(busy), 64'(0));
    check("rst_mid.outputs", 64'({row, col}), 64'(0));
    check("rst_mid.apq", 64'(a_pq), 64'(0));
    step();
    reset = 1'b0;
    for (int c = 201; c < 210; c++) step();
    set_identity();
    set_pair(10, 11, 32'h3000_0000);
    do_case("after_reset", 90);

`ifdef JACOBI_PIVOT_THRESH_EN
    set_identity();
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++)
        set_pair(i, j, 32'h0000_0100);
    thresh = 32'h0001_0000;
    do_case("thr_conv", 0);
    thresh = 32'h0000_0080;
    do_case("thr_ready", 0);
    thresh = 32'h0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jacobi_pivot_search.md
# jacobi_pivot_search

- Upstream stage of the Givens rotation builder in the Jacobi eigen-solver.
- Scans the strict upper triangle of the symmetric working matrix through a synchronous read port and selects the off-diagonal element of largest magnitude as the rotation pivot (p,q).
- Fetches a_pp and a_qq, then presents row/col plus the three values with a one-cycle `ready_flag` pulse.
- The angle/cos/sin stage and the Givens matrix stage consume these outputs.

## Interface
Parameters:
- N, 32, matrix dimension (N ≥ 2)
- W, 32, element width; signed Q2.30 two's complement, 1.0 = 0x40000000
- AW, $clog2(N), row/column index width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  begin a scan; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- mat_rd_en  out  1  matrix read request
- mat_rd_row  out  AW  read row index
- mat_rd_col  out  AW  read column index
- mat_rd_data  in  W  read data, valid exactly 1 cycle after mat_rd_en
- thresh  in  W  convergence threshold, unsigned magnitude (used only with JACOBI_PIVOT_THRESH_EN)
- row  out  AW  pivot p (p < q)
- col  out  AW  pivot q
- a_pp, a_qq, a_pq  out  W  diagonal and pivot values, signed, unmodified
- ready_flag  out  1  one-cycle pulse; pivot outputs valid
- converged  out  1  one-cycle pulse; off-diagonal max is below thresh

## Operation
- States: IDLE, SCAN, FLUSH, RD_PP, RD_QQ, CAP, DONE.
- IDLE → SCAN when start = 1. A start seen in any other state is ignored.
- SCAN:
  - Issues one read per cycle over P = N(N−1)/2 pairs in order i = 0..N−2, j = i+1..N−1 (row-major).
  - After the last pair, goes to FLUSH.
- Compare pipeline:
  - Returning data is registered with its (i,j) tag.
  - |x| is computed with saturation: 0x80000000 → 0x7FFFFFFF.
  - The first returned element unconditionally loads the max register.
  - Later elements replace it only if strictly greater. On ties the earliest pair in scan order wins.
- FLUSH: last comparison completes; no read issued.
- RD_PP: read (p,p). RD_QQ: read (q,q). CAP: capture a_qq. a_pp is captured in the cycle data returns.
- DONE:
  - Drives row, col, a_pp, a_qq, a_pq. a_pq is the signed stored value, not its magnitude.
  - Pulses ready_flag (or converged, see Configuration), then returns to IDLE.
- Outputs row/col/a_* hold until the next DONE.
- mat_rd_row/col are 0 whenever mat_rd_en = 0.
- Reset mid-operation: immediately IDLE, no pulse emitted, partial results discarded.

## Timing
- Start sampled at cycle 0.
- SCAN issues reads at cycles 1..P.
- FLUSH at cycle P+1, RD_PP at P+2, RD_QQ at P+3, CAP at P+4, DONE at P+5.
- For N = 32 (P = 496): ready_flag is high in cycle 501; busy is high in cycles 1..501.
- Earliest next start is accepted at cycle 502.
- Reset values: busy, mat_rd_en, ready_flag, converged = 0; row, col, mat_rd_row, mat_rd_col = 0; a_pp, a_qq, a_pq = 0.

## Configuration
- JACOBI_PIVOT_THRESH_EN defined:
  - In DONE, if the saturated |a_pq| < thresh, converged pulses instead of ready_flag.
  - Timing and outputs are otherwise identical.
- Not defined:
  - thresh is ignored, converged is tied to 0, and ready_flag always pulses.

## Test plan
- Identity matrix with a(3,7) = a(7,3) = 0x20000000; start → ready_flag at cycle 501, row = 3, col = 7, a_pq = 0x20000000, a_pp = a_qq = 0x40000000.
- a(1,2) = 0x10000000 and a(5,9) = 0xF0000000 (equal magnitude) → row = 1, col = 2.
- a(0,4) = 0x28000000 and a(6,8) = 0xD0000000 → row = 6, col = 8, a_pq = 0xD0000000 (sign preserved).
- a(2,30) = 0x80000000 and a(0,1) = 0x7FFFFFFF → saturated tie, earliest wins: row = 0, col = 1.
- Reset at cycle 200, then start at cycle 210 with a(10,11) = 0x30000000:
  - No pulse before cycle 711.
  - ready_flag at cycle 711 with row = 10, col = 11.
  - start asserted at cycle 300 is ignored.
- With JACOBI_PIVOT_THRESH_EN, thresh = 0x00010000, all off-diagonals 0x00000100 → converged pulse at cycle 501, ready_flag stays 0. Rerun with thresh = 0x00000080 → ready_flag pulse, converged stays 0.
